// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the Goldschmidt mantissa divider controller.
// Holds the step-state enum, the datapath mux encodings and the per-step decoders.
package fpdiv_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT_D = 3'd1,
      INIT_N = 3'd2,
      ITER_N = 3'd3,
      ITER_D = 3'd4,
      DONE   = 3'd5
   } state_e;

   localparam logic [1:0] SELA_REGA = 2'b00;
   localparam logic [1:0] SELA_D    = 2'b01;
   localparam logic [1:0] SELA_IA   = 2'b10;

   localparam logic [1:0] SELB_D    = 2'b00;
   localparam logic [1:0] SELB_X    = 2'b01;
   localparam logic [1:0] SELB_REGB = 2'b10;
   localparam logic [1:0] SELB_REGC = 2'b11;

   // Initial reciprocal approximation (0.75 in 1.23 fixed point).
   localparam logic [23:0] IA = 24'h60_0000;

   typedef struct packed {
      logic a;
      logic b;
      logic c;
   } load_t;

   function automatic load_t load_decode(input state_e s);
      load_t ld;
      ld = '{a: 1'b0, b: 1'b0, c: 1'b0};
      case (s)
         INIT_D:  ld = '{a: 1'b1, b: 1'b0, c: 1'b1};
         INIT_N:  ld = '{a: 1'b0, b: 1'b1, c: 1'b0};
         ITER_N:  ld = '{a: 1'b0, b: 1'b1, c: 1'b0};
         ITER_D:  ld = '{a: 1'b1, b: 1'b0, c: 1'b1};
         default: ld = '{a: 1'b0, b: 1'b0, c: 1'b0};
      endcase
      return ld;
   endfunction

   // Returns {muxa, muxb}; IDLE and DONE park both muxes at zero.
   function automatic logic [3:0] sel_decode(input state_e s);
      logic [3:0] sel;
      sel = 4'b0000;
      case (s)
         INIT_D:  sel = {SELA_IA,   SELB_D};
         INIT_N:  sel = {SELA_IA,   SELB_X};
         ITER_N:  sel = {SELA_REGA, SELB_REGB};
         ITER_D:  sel = {SELA_REGA, SELB_REGC};
         default: sel = {SELA_REGA, SELB_D};
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/fpdiv_load_retime.sv
// Falling-edge retiming of the datapath load enables so that clk&load
// gating in the datapath never sees a glitch or a truncated pulse.
module fpdiv_load_retime
   import fpdiv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] load_i,
   output logic [2:0] load_o
);

   logic [2:0] load_q;

   // Capture the step's enables while clk is low; reset clears them at once.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         load_q <= 3'b000;
      end else begin
         load_q <= load_i;
      end
   end

   assign load_o = load_q;

endmodule

// File: rtl/fpdiv_ctrl.sv
// Step sequencer for the Goldschmidt divider datapath: start/busy/done handshake,
// operand mux selects and retimed register load enables.
module fpdiv_ctrl
   import fpdiv_pkg::*;
#(
   parameter int ITER = 3,
   parameter int CW   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [1:0] sel_muxa,
   output logic [1:0] sel_muxb,
   output logic       load_rega,
   output logic       load_regb,
   output logic       load_regc
);

   localparam logic [CW-1:0] ITER_LAST = CW'(ITER - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sel_a_q, sel_a_d;
   logic [1:0]    sel_b_q, sel_b_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [2:0]    load_s;
   logic [2:0]    load_rt_s;

   // Next-state/counter logic; outputs are decoded from the next state so the
   // registered copies line up with the state they describe.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = INIT_D;
            end else begin
               state_d = IDLE;
            end
         end
         INIT_D: state_d = INIT_N;
         INIT_N: begin
            state_d = ITER_N;
            cnt_d   = {CW{1'b0}};
         end
         ITER_N: begin
            // The last iteration skips its D update and goes straight to DONE.
            if (cnt_q == ITER_LAST) begin
               state_d = DONE;
            end else begin
               state_d = ITER_D;
            end
         end
         ITER_D: begin
            state_d = ITER_N;
            cnt_d   = cnt_q + CNT_ONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      {sel_a_d, sel_b_d} = sel_decode(state_d);
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
      load_s = load_decode(state_q);
   end

   // State, iteration counter and registered handshake/select outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= {CW{1'b0}};
         sel_a_q <= 2'b00;
         sel_b_q <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   fpdiv_load_retime u_load_retime (
      .clk    (clk),
      .reset  (reset),
      .load_i (load_s),
      .load_o (load_rt_s)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign sel_muxa  = sel_a_q;
   assign sel_muxb  = sel_b_q;
   assign load_rega = load_rt_s[2];
   assign load_regb = load_rt_s[1];
   assign load_regc = load_rt_s[0];

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Scoreboard bench for fpdiv_ctrl: stimulus queues one expected record per
// cycle, a monitor compares the DUT once per cycle just before the rising edge.
module tb_fpdiv_ctrl;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       busy, done;
   logic [1:0] sel_muxa, sel_muxb;
   logic       load_rega, load_regb, load_regc;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [2:0] ld;
   } exp_t;

   exp_t exp_q[$];
   int   checks     = 0;
   int   errors     = 0;
   int   dones_seen = 0;
   int   dones_exp  = 0;

   fpdiv_ctrl #(.ITER(3), .CW(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .sel_muxa  (sel_muxa),
      .sel_muxb  (sel_muxb),
      .load_rega (load_rega),
      .load_regb (load_regb),
      .load_regc (load_regc)
   );

   always #5 clk = ~clk;

   // Hand-computed step table for ITER=3: {busy, done, muxa, muxb, {a,b,c}}.
   function automatic exp_t op_step(input int k);
      exp_t e;
      case (k)
         0:       e = {1'b1, 1'b0, 2'b10, 2'b00, 3'b101};
         1:       e = {1'b1, 1'b0, 2'b10, 2'b01, 3'b010};
         2:       e = {1'b1, 1'b0, 2'b00, 2'b10, 3'b010};
         3:       e = {1'b1, 1'b0, 2'b00, 2'b11, 3'b101};
         4:       e = {1'b1, 1'b0, 2'b00, 2'b10, 3'b010};
         5:       e = {1'b1, 1'b0, 2'b00, 2'b11, 3'b101};
         6:       e = {1'b1, 1'b0, 2'b00, 2'b10, 3'b010};
         7:       e = {1'b1, 1'b1, 2'b00, 2'b00, 3'b000};
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic exp_t dut_now();
      return {busy, done, sel_muxa, sel_muxb, load_rega, load_regb, load_regc};
   endfunction

   task automatic push_op();
      for (int k = 0; k < 8; k++) exp_q.push_back(op_step(k));
   endtask

   // One-cycle start pulse; the cycle before the start-sample edge is idle.
   task automatic issue_op();
      @(posedge clk); #1;
      start = 1'b1;
      exp_q.push_back('0);
      push_op();
      dones_exp++;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic check_now(input string name, input exp_t want);
      exp_t got;
      got = dut_now();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b required %b at %0t", name, got, want, $time);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
   endtask

   // Scoreboard monitor: every cycle pops an expected record (idle if none).
   always @(negedge clk) begin
      #3;
      if (reset === 1'b0) begin
         exp_t e;
         exp_t a;
         a = dut_now();
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else                  e = '0;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL step: got %b required %b at %0t", a, e, $time);
         end
         if (done === 1'b1) dones_seen++;
      end
   end

   // Load enables may only move while clk is low.
   always @(load_rega or load_regb or load_regc) begin
      if (reset === 1'b0) begin
         checks++;
         if (clk !== 1'b0) begin
            errors++;
            $display("FAIL load_edge: load changed with clk=%b required clk=0 at %0t", clk, $time);
         end
      end
   end

   initial begin
      // Reset held for two cycles.
      #12;
      check_now("reset_outputs", '0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(posedge clk);

      // Single divide.
      issue_op();
      wait_drain();
      repeat (3) @(posedge clk);

      // start held high: second divide after exactly one idle cycle.
      @(posedge clk); #1;
      start = 1'b1;
      exp_q.push_back('0);
      push_op();
      exp_q.push_back('0);
      push_op();
      dones_exp += 2;
      repeat (12) @(posedge clk);
      #1;
      start = 1'b0;
      wait_drain();
      repeat (3) @(posedge clk);

      // start pulse in cycle 4 of a busy op is ignored.
      issue_op();
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_drain();
      repeat (4) @(posedge clk);

      // Async reset mid-cycle in ITER_D, with clk low and a,c loads up.
      issue_op();
      repeat (3) @(posedge clk);
      #6;
      check_now("pre_reset_iter_d", {1'b1, 1'b0, 2'b00, 2'b11, 3'b101});
      reset = 1'b1;
      exp_q.delete();
      dones_exp--;
      #1;
      check_now("async_reset", '0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      issue_op();
      wait_drain();
      repeat (4) @(posedge clk);

      checks++;
      if (dones_seen != dones_exp) begin
         errors++;
         $display("FAIL done_count: got %0d required %0d", dones_seen, dones_exp);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpdiv_ctrl.md
Name: fpdiv_ctrl

Overview:
Sequencing controller for the Goldschmidt floating-point mantissa divider datapath (fpdiv). It accepts a start/busy/done handshake from the requester and drives the datapath's operand-mux selects and register load enables through the init and iteration steps. It also signals when q (regb) holds the quotient. It sits directly beside the datapath instance in the FP divide unit.

Parameters:
ITER, 3, number of Goldschmidt iterations after init (legal 1..15)
CW, 4, iteration counter width (must hold ITER)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  request divide; d and x held stable by requester from start-sample edge until done
busy  output  1  high while a divide is in progress (INIT_D through DONE)
done  output  1  one-cycle pulse; datapath q valid this cycle
sel_muxa  output  2  datapath mux A select: 00 rega, 01 d, 10 initial approx (0.75)
sel_muxb  output  2  datapath mux B select: 00 d, 01 x, 10 regb, 11 regc
load_rega  output  1  datapath rega clock-gate enable
load_regb  output  1  datapath regb clock-gate enable
load_regc  output  1  datapath regc clock-gate enable

Behaviour:
- One clock, clk. Reset is asynchronous and active-high, named reset.
- State and counter update on posedge clk.
- sel_* are decoded combinationally from state and are stable for the whole step cycle.
- load_* are decoded from state, then retimed through negedge-clk flops. They rise at mid-cycle while clk is low, stay stable across exactly one rising edge (the end of the step cycle), and fall at the next falling edge. This gives glitch-free clk&load gating in the datapath.
- Reset values: state IDLE, counter 0, all outputs 0. The negedge flops are also async-reset.
- States and step outputs (muxa/muxb -> loads):
  - IDLE: sel 00/00, no loads. start=1 goes to INIT_D.
  - INIT_D: ia × d, sel 10/00 -> rega (K0 = 2 − D0), regc (D0). Goes to INIT_N.
  - INIT_N: ia × x, sel 10/01 -> regb (N0). Counter clears to 0. Goes to ITER_N.
  - ITER_N: rega × regb, sel 00/10 -> regb. If counter == ITER−1, go to DONE. Otherwise go to ITER_D.
  - ITER_D: rega × regc, sel 00/11 -> rega, regc. Counter increments. Goes to ITER_N.
  - DONE: done=1, busy=1, no loads, sel 00/00. Goes to IDLE.
- The final iteration performs only the N step; the trailing D update is skipped.
- Latency: if start is sampled at edge 0, done is high in cycle 2·ITER+2 (cycle 8 for ITER=3). The last regb capture occurs at edge 2·ITER+1.
- start while busy is ignored. start held high in DONE does not restart; it is re-sampled only in IDLE, so back-to-back divides have one idle cycle between them.
- Reset mid-operation: returns to IDLE immediately (async). load_* drop without waiting for the falling edge. The datapath register contents are don't-care.
- Hold margin: sel changes at the same posedge that captures the previous step. The datapath's clk-to-q plus multiplier delay covers hold; the integration STA check owns this.

Decomposition:
- Package fpdiv_pkg holds:
  - the state enum (IDLE, INIT_D, INIT_N, ITER_N, ITER_D, DONE);
  - select constants (SELA_REGA=00, SELA_D=01, SELA_IA=10, SELB_D=00, SELB_X=01, SELB_REGB=10, SELB_REGC=11);
  - the IA constant 24'h60_0000.
- One natural sub-module, fpdiv_load_retime: a 3-bit negedge flop with async reset that produces the load_* outputs.

Test Plan:
- Reset then idle: assert reset for 2 cycles -> all outputs 0. With start=0 for 10 cycles -> state stays IDLE, no load pulses.
- Single divide, ITER=3, start pulse at edge 0 -> done only in cycle 8, busy high cycles 1–8.
  - sel sequence 10/00, 10/01, then 00/10, 00/11, 00/10, 00/11, 00/10.
  - Load pattern per step: {a,c}, {b}, {b}, {a,c}, {b}, {a,c}, {b}.
- Gated-clock check: per step, load_* rises only while clk=0 and falls only while clk=0 -> clk&load shows exactly one pulse per load, none truncated.
- With fpdiv attached, x=24'hC0_0000 (1.5) and d=24'h80_0000 (1.0) -> q=24'hC0_0000 ±1 ulp at done. Then d=24'hC0_0000, x=24'h80_0000 -> q≈24'h55_5555 (0.6667) ±2 ulp.
- start held high through DONE -> second divide begins only after one IDLE cycle. A start pulse at cycle 4 of a busy op is ignored, with no extra done.
- Async reset asserted mid-cycle during ITER_D -> outputs 0 immediately. After release, the next start yields a full-length 8-cycle sequence.
